// File: rtl/mul_share_pkg.sv
// Shared types and sizing helpers for the multiplier-sharing controller.
package mul_share_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        START,
        WAIT,
        RESP,
        CLR_EXIT
    } state_t;

    localparam int DEF_W   = 16;
    localparam int DEF_TMO = 2**DEF_W + 8;

    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

    // Wide enough to hold TMO_CYC itself, so the counter can saturate there.
    function automatic int cnt_width(input int tmo);
        return $clog2(tmo + 1);
    endfunction

endpackage

// File: rtl/mul_share_ctrl_rr_arbiter.sv
// Round-robin picker: combinational search from a registered pointer that
// moves one past the served requester whenever an operation completes.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    input  logic [IW-1:0]   adv_idx,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx,
    output logic            found
);

    logic [IW-1:0] ptr_reg;
    logic [IW-1:0] ptr_next;
    logic [IW:0]   sum;

    // Walk offsets from farthest to nearest so the nearest asserted bit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_reg} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            if (req[sum[IW-1:0]]) begin
                found = 1'b1;
                idx   = sum[IW-1:0];
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
        assign onehot[gi] = found && (idx == IW'(gi));
    end

    assign ptr_next = (adv_idx == IW'(NREQ - 1)) ? '0 : adv_idx + IW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg <= '0;
        end else if (advance) begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one iterative multiplier unit among NREQ clients: arbitrate, clear,
// start, wait (with timeout), respond, clear again.
module mul_share_ctrl
    import mul_share_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = DEF_W,
    parameter int TMO_CYC = DEF_TMO
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*W-1:0]          a_in,
    input  logic [NREQ*W-1:0]          b_in,
    output logic [NREQ-1:0]            gnt,
    output logic [NREQ-1:0]            rsp_valid,
    output logic                       rsp_err,
    output logic [prod_width(W)-1:0]   rsp_product,
    output logic                       busy,
    output logic                       mul_rst,
    output logic                       mul_start,
    output logic [W-1:0]               mul_a,
    output logic [W-1:0]               mul_b,
    input  logic                       mul_done,
    input  logic [prod_width(W)-1:0]   mul_product
);

    localparam int PW = prod_width(W);
    localparam int CW = cnt_width(TMO_CYC);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t        state_reg, state_next;
    logic [IW-1:0] idx_reg;
    logic [W-1:0]  a_reg, b_reg;
    logic [PW-1:0] prod_reg;
    logic          err_reg;
    logic [CW-1:0] cnt_reg;

    logic [NREQ-1:0] arb_onehot;
    logic [IW-1:0]   arb_idx;
    logic            arb_found;
    logic [W-1:0]    a_arr [NREQ];
    logic [W-1:0]    b_arr [NREQ];
    logic [W-1:0]    a_sel, b_sel;
    logic            timeout;
    logic            hold;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .advance (state_reg == RESP),
        .adv_idx (idx_reg),
        .onehot  (arb_onehot),
        .idx     (arb_idx),
        .found   (arb_found)
    );

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign a_arr[gi] = a_in[gi*W +: W];
        assign b_arr[gi] = b_in[gi*W +: W];
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_onehot[i]) begin
                a_sel = a_sel | a_arr[i];
                b_sel = b_sel | b_arr[i];
            end
        end
    end

    assign timeout = (cnt_reg == CW'(TMO_CYC - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (arb_found) begin
                    state_next = (a_sel == '0 || b_sel == '0) ? RESP : CLR;
                end
            end
            CLR:      state_next = START;
            START:    state_next = WAIT;
            WAIT: begin
                if (mul_done || timeout) begin
                    state_next = RESP;
                end
            end
            RESP:     state_next = CLR_EXIT;
            CLR_EXIT: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            prod_reg  <= '0;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == WAIT) begin
                if (cnt_reg != CW'(TMO_CYC)) begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end else begin
                cnt_reg <= '0;
            end
            if (state_reg == IDLE && arb_found) begin
                idx_reg  <= arb_idx;
                a_reg    <= a_sel;
                b_reg    <= b_sel;
                prod_reg <= '0;
                err_reg  <= 1'b0;
            end
            // A late done still beats the timeout in the same cycle.
            if (state_reg == WAIT) begin
                if (mul_done) begin
                    prod_reg <= mul_product;
                end else if (timeout) begin
                    prod_reg <= '0;
                    err_reg  <= 1'b1;
                end
            end
        end
    end

    assign hold = (state_reg == CLR) || (state_reg == START) ||
                  (state_reg == WAIT) || (state_reg == RESP);

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_out
        assign gnt[gi]       = hold && (idx_reg == IW'(gi));
        assign rsp_valid[gi] = (state_reg == RESP) && (idx_reg == IW'(gi));
    end

    assign rsp_err     = (state_reg == RESP) && err_reg;
    assign rsp_product = (state_reg == RESP) ? prod_reg : '0;
    assign busy        = (state_reg != IDLE);
    assign mul_rst     = !reset_n || (state_reg == CLR) || (state_reg == CLR_EXIT);
    assign mul_start   = (state_reg == START);
    assign mul_a       = a_reg;
    assign mul_b       = b_reg;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for mul_share_ctrl with a transaction-level arbitration model
// and a simple iterative-multiplier unit model.
module tb_mul_share_ctrl;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int TMO  = 20;
    localparam int LAT  = 8;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [W-1:0]    a_v [NREQ];
    logic [W-1:0]    b_v [NREQ];
    logic [NREQ*W-1:0] a_in, b_in;
    logic [NREQ-1:0] gnt, rsp_valid;
    logic            rsp_err, busy, mul_rst, mul_start;
    logic [2*W-1:0]  rsp_product;
    logic [W-1:0]    mul_a, mul_b;
    logic            done_m = 1'b0;
    logic [2*W-1:0]  prod_m = '0;
    bit              running = 1'b0;
    int              cnt_m = 0;
    bit              hang = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    int start_cnt = 0;
    int rst_cnt = 0;
    int ptr_m = 0;

    typedef struct {
        int             idx;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] prod;
        logic           err;
    } exp_t;
    exp_t exp_q [$];

    assign a_in = {a_v[3], a_v[2], a_v[1], a_v[0]};
    assign b_in = {b_v[3], b_v[2], b_v[1], b_v[0]};

    always #5 clk = ~clk;

    mul_share_ctrl #(.NREQ(NREQ), .W(W), .TMO_CYC(TMO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .a_in        (a_in),
        .b_in        (b_in),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_err     (rsp_err),
        .rsp_product (rsp_product),
        .busy        (busy),
        .mul_rst     (mul_rst),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_done    (done_m),
        .mul_product (prod_m)
    );

    // Unit model: done LAT cycles after start, sticky until cleared.
    always @(posedge clk) begin
        if (mul_rst) begin
            done_m  <= 1'b0;
            running <= 1'b0;
            prod_m  <= '0;
        end else if (mul_start) begin
            running <= 1'b1;
            cnt_m   <= LAT;
            prod_m  <= {16'b0, mul_a} * {16'b0, mul_b};
        end else if (running && !hang) begin
            if (cnt_m == 1) begin
                done_m  <= 1'b1;
                running <= 1'b0;
            end
            cnt_m <= cnt_m - 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] mask, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (mask[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic push_exp(input logic [3:0] mask);
        exp_t e;
        bit   zero;
        e.idx  = rr_pick(mask, ptr_m);
        e.a    = a_v[e.idx];
        e.b    = b_v[e.idx];
        zero   = (e.a == 0) || (e.b == 0);
        e.prod = (zero || hang) ? 32'd0 : 32'(e.a) * 32'(e.b);
        e.err  = !zero && hang;
        exp_q.push_back(e);
        ptr_m = (e.idx + 1) % NREQ;
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (mul_start) start_cnt++;
            if (mul_rst) rst_cnt++;
        end
    end

    // Every-cycle comparison against the model's head-of-queue transaction.
    always @(negedge clk) begin
        if (reset_n) begin
            if (!busy) chk("idle_mul_rst", {63'b0, mul_rst}, 64'd0);
            if (gnt != 0) begin
                if (exp_q.size() == 0) begin
                    chk("stray_gnt", {60'b0, gnt}, 64'd0);
                end else begin
                    chk("gnt", {60'b0, gnt}, 64'(4'b0001 << exp_q[0].idx));
                    chk("mul_a", {48'b0, mul_a}, {48'b0, exp_q[0].a});
                    chk("mul_b", {48'b0, mul_b}, {48'b0, exp_q[0].b});
                end
            end
            if (rsp_valid != 0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", {60'b0, rsp_valid}, 64'd0);
                end else begin
                    chk("rsp_valid", {60'b0, rsp_valid}, 64'(4'b0001 << exp_q[0].idx));
                    chk("rsp_product", {32'b0, rsp_product}, {32'b0, exp_q[0].prod});
                    chk("rsp_err", {63'b0, rsp_err}, {63'b0, exp_q[0].err});
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        chk("back_to_idle", {63'b0, busy}, 64'd0);
    endtask

    task automatic wait_rsp(output int cyc);
        for (cyc = 1; cyc <= 200; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid != 0) break;
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] mask, input logic [3:0] gnt_lit,
                          input int lat, input logic [31:0] prod_lit, input logic err_lit,
                          input bit mutate);
        int cyc;
        push_exp(mask);
        start_cnt = 0;
        rst_cnt   = 0;
        req       = mask;
        for (cyc = 1; cyc <= 200; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (cyc == 1) begin
                chk({name, "_gnt"}, {60'b0, gnt}, {60'b0, gnt_lit});
                req = '0;
            end
            if (mutate && cyc == 5) b_v[1] = 16'd100;
            if (rsp_valid != 0) break;
        end
        $display("op %s: latency %0d product %0d err %0b", name, cyc, rsp_product, rsp_err);
        chk({name, "_latency"}, 64'(cyc), 64'(lat));
        chk({name, "_product"}, {32'b0, rsp_product}, {32'b0, prod_lit});
        chk({name, "_err"}, {63'b0, rsp_err}, {63'b0, err_lit});
        wait_idle();
    endtask

    logic [3:0]  rr_gnt  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [31:0] rr_prod [5] = '{32'd3, 32'd12, 32'd25, 32'd42, 32'd3};

    initial begin
        int cyc;
        for (int i = 0; i < NREQ; i++) begin
            a_v[i] = '0;
            b_v[i] = '0;
        end

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_gnt", {60'b0, gnt}, 64'd0);
        chk("rst_rsp_valid", {60'b0, rsp_valid}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_mul_rst", {63'b0, mul_rst}, 64'd1);
        chk("rst_mul_start", {63'b0, mul_start}, 64'd0);
        chk("rst_mul_ab", {32'b0, mul_a, mul_b}, 64'd0);
        chk("rst_product", {32'b0, rsp_product}, 64'd0);
        chk("rst_err", {63'b0, rsp_err}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_mul_rst", {63'b0, mul_rst}, 64'd0);

        // Single request: 7*5
        a_v[0] = 16'd7; b_v[0] = 16'd5;
        run_op("single", 4'b0001, 4'b0001, 12, 32'd35, 1'b0, 1'b0);
        chk("single_starts", 64'(start_cnt), 64'd1);
        chk("single_clears", 64'(rst_cnt), 64'd2);

        // Async reset in the middle of WAIT
        a_v[1] = 16'd5; b_v[1] = 16'd5; hang = 1'b1;
        push_exp(4'b0010);
        req = 4'b0010;
        @(negedge clk);
        req = '0;
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_gnt", {60'b0, gnt}, 64'd0);
        chk("arst_busy", {63'b0, busy}, 64'd0);
        chk("arst_mul_rst", {63'b0, mul_rst}, 64'd1);
        chk("arst_mul_start", {63'b0, mul_start}, 64'd0);
        chk("arst_mul_ab", {32'b0, mul_a, mul_b}, 64'd0);
        chk("arst_rsp_valid", {60'b0, rsp_valid}, 64'd0);
        exp_q.delete();
        ptr_m = 0;
        hang  = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("arst_quiet", {63'b0, busy}, 64'd0);

        // Round robin with all requests held
        for (int i = 0; i < NREQ; i++) begin
            a_v[i] = W'(i + 3);
            b_v[i] = W'(2 * i + 1);
        end
        repeat (5) push_exp(4'b1111);
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_rsp(cyc);
            $display("rr %0d: gap %0d rsp_valid %b product %0d", n, cyc, rsp_valid, rsp_product);
            chk("rr_gap", 64'(cyc), (n == 0) ? 64'd12 : 64'd14);
            chk("rr_winner", {60'b0, rsp_valid}, {60'b0, rr_gnt[n]});
            chk("rr_product", {32'b0, rsp_product}, {32'b0, rr_prod[n]});
            if (n == 4) req = '0;
        end
        wait_idle();

        // Zero fast path
        a_v[2] = 16'd0; b_v[2] = 16'd9;
        run_op("zero", 4'b0100, 4'b0100, 1, 32'd0, 1'b0, 1'b0);
        chk("zero_starts", 64'(start_cnt), 64'd0);
        chk("zero_clears", 64'(rst_cnt), 64'd1);

        // Timeout, then the pointer must have moved past requester 3
        a_v[3] = 16'd3; b_v[3] = 16'd4; hang = 1'b1;
        run_op("tmo", 4'b1000, 4'b1000, 3 + TMO, 32'd0, 1'b1, 1'b0);
        hang = 1'b0;
        a_v[0] = 16'd2; b_v[0] = 16'd11;
        run_op("after_tmo", 4'b1001, 4'b0001, 12, 32'd22, 1'b0, 1'b0);

        // Operand change and request drop mid-operation
        a_v[1] = 16'd9; b_v[1] = 16'd6;
        run_op("opchg", 4'b0010, 4'b0010, 12, 32'd54, 1'b0, 1'b1);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
